// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator datapath and its successive-approximation searcher.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int CMP_W = 4;
  localparam int CNT_W = $clog2(CMP_W + 1);

  // Width needed to count 0..w comparisons.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cmp_search_if.sv
// Handshake plus comparator bus between the searcher and its environment.
interface cmp_search_if #(parameter int W = cmp_pkg::CMP_W);

  localparam int CW = cmp_pkg::cnt_width(W);

  logic          start;
  logic [W-1:0]  guess;
  logic          eq;
  logic          lt;
  logic          gt;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          err;
  logic [CW-1:0] probes;

  modport master (
    input  start, eq, lt, gt,
    output guess, busy, done, result, err, probes
  );

  modport slave (
    output start, eq, lt, gt,
    input  guess, busy, done, result, err, probes
  );

endinterface

// File: rtl/cmp_search.sv
// Successive-approximation searcher: recovers an unknown comparator operand
// one bit per cycle, MSB first, with early exit on equality.
module cmp_search
  import cmp_pkg::*;
#(
  parameter int W = CMP_W
) (
  input  logic            clk,
  input  logic            rst_b,
  cmp_search_if.master    bus
);

  localparam int CW = cnt_width(W);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_PROBE = PROBE;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]    state;
  logic [W-1:0]  acc;
  logic [IW-1:0] bitidx;
  logic [CW-1:0] cnt;
  logic [W-1:0]  result_q;
  logic          err_q;
  logic [CW-1:0] probes_q;

  logic [W-1:0]  bitmask;
  logic [W-1:0]  trial;
  logic [CW-1:0] cnt_next;
  logic [2:0]    answer;
  logic          last_bit;

  always_comb begin
    bitmask         = '0;
    bitmask[bitidx] = 1'b1;
    trial           = acc | bitmask;
  end

  assign cnt_next = cnt + CW'(1);
  assign answer   = {bus.eq, bus.lt, bus.gt};
  assign last_bit = (bitidx == '0);

  assign bus.guess  = (state == ST_PROBE) ? trial : '0;
  assign bus.busy   = (state == ST_PROBE);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.probes = probes_q;

  // Each PROBE edge consumes one comparator answer; any answer that is not
  // exactly one-hot aborts with acc left as it was before this probe.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= ST_IDLE;
      acc      <= '0;
      bitidx   <= '0;
      cnt      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      probes_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            acc    <= '0;
            bitidx <= IW'(W - 1);
            cnt    <= '0;
            err_q  <= 1'b0;
            state  <= ST_PROBE;
          end
        end
        ST_PROBE: begin
          cnt <= cnt_next;
          case (answer)
            3'b100: begin
              acc      <= trial;
              result_q <= trial;
              probes_q <= cnt_next;
              state    <= ST_DONE;
            end
            3'b001: begin
              acc <= trial;
              if (last_bit) begin
                result_q <= trial;
                probes_q <= cnt_next;
                state    <= ST_DONE;
              end else begin
                bitidx <= bitidx - IW'(1);
              end
            end
            3'b010: begin
              if (last_bit) begin
                result_q <= acc;
                probes_q <= cnt_next;
                state    <= ST_DONE;
              end else begin
                bitidx <= bitidx - IW'(1);
              end
            end
            default: begin
              err_q    <= 1'b1;
              result_q <= acc;
              probes_q <= cnt_next;
              state    <= ST_DONE;
            end
          endcase
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_search.sv
// Closed-loop bench: behavioural comparator on the searcher's guess, scoreboard
// of expected results checked by an independent done monitor.
module tb_cmp_search;

  localparam int W = 4;

  typedef struct {
    int result;
    int probes;
    int err;
    int t0;
  } exp_t;

  logic       clk;
  logic       rst_b;
  logic [W-1:0] secret;
  logic       fault_en;
  logic [W-1:0] fault_guess;
  int         cyc;
  int         total;
  int         bad;
  exp_t       sb[$];

  cmp_search_if #(.W(W)) bus();

  cmp_search #(.W(W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal comparator, optionally corrupted on one guess value.
  always_comb begin
    bus.eq = (secret == bus.guess);
    bus.lt = (secret <  bus.guess);
    bus.gt = (secret >  bus.guess);
    if (fault_en && bus.guess == fault_guess) begin
      bus.eq = 1'b1;
      bus.lt = 1'b1;
      bus.gt = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // A binary search that stops on equality needs one probe per bit down to
  // the lowest set bit of the secret; a zero secret uses every bit.
  function automatic int refProbes(input int s);
    int v;
    int tz;
    if (s == 0) return W;
    v  = s;
    tz = 0;
    while (v % 2 == 0) begin
      v  = v / 2;
      tz++;
    end
    return W - tz;
  endfunction

  task automatic applyStimulus(input int s, input bit poke, input int exp_res,
                               input int exp_probes, input int exp_err);
    exp_t e;
    bit   seen;
    @(negedge clk);
    secret    = W'(s);
    bus.start = 1'b1;
    e.result  = exp_res;
    e.probes  = exp_probes;
    e.err     = exp_err;
    e.t0      = cyc;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 1; i <= 24 && !seen; i++) begin
      @(negedge clk);
      bus.start = poke && (i == 1);
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout: no done for secret %0d (got 0 expected 1)", s);
      if (sb.size() != 0) void'(sb.pop_back());
    end else begin
      @(negedge clk);
      checkOutput("done_pulse", int'(bus.done), 0);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Monitor: every done pops the oldest expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1 expected 0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result",  int'(bus.result), e.result);
        checkOutput("probes",  int'(bus.probes), e.probes);
        checkOutput("err",     int'(bus.err),    e.err);
        checkOutput("latency", cyc - e.t0,       e.probes + 1);
      end
    end
  end

  task automatic checkReset(input string tag);
    checkOutput({tag, "_guess"},  int'(bus.guess),  0);
    checkOutput({tag, "_busy"},   int'(bus.busy),   0);
    checkOutput({tag, "_done"},   int'(bus.done),   0);
    checkOutput({tag, "_result"}, int'(bus.result), 0);
    checkOutput({tag, "_err"},    int'(bus.err),    0);
    checkOutput({tag, "_probes"}, int'(bus.probes), 0);
  endtask

  initial begin
    int s;
    total       = 0;
    bad         = 0;
    cyc         = 0;
    rst_b       = 1'b0;
    bus.start   = 1'b0;
    secret      = '0;
    fault_en    = 1'b0;
    fault_guess = '0;
    #1;
    checkReset("reset");
    repeat (3) @(negedge clk);
    rst_b = 1'b1;

    applyStimulus(0,  1'b0, 0,  refProbes(0),  0);
    applyStimulus(11, 1'b0, 11, refProbes(11), 0);
    applyStimulus(8,  1'b0, 8,  refProbes(8),  0);
    applyStimulus(15, 1'b0, 15, refProbes(15), 0);

    for (int i = 0; i < (1 << W); i++)
      applyStimulus(i, 1'b0, i, refProbes(i), 0);

    // Second probe of secret 9 is guess 12; make it answer eq and lt together.
    fault_en    = 1'b1;
    fault_guess = W'(12);
    applyStimulus(9, 1'b0, 8, 2, 1);
    fault_en    = 1'b0;

    // Abort a search in its third probe; the result must not be reported.
    @(negedge clk);
    secret    = W'(5);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid_busy", int'(bus.busy), 1);
    rst_b = 1'b0;
    #1;
    checkReset("midreset");
    repeat (2) @(negedge clk);
    checkOutput("held_done", int'(bus.done), 0);
    rst_b = 1'b1;

    applyStimulus(5, 1'b0, 5, refProbes(5), 0);

    for (int i = 0; i < 24; i++) begin
      s = int'($urandom_range(0, (1 << W) - 1));
      applyStimulus(s, 1'($urandom_range(0, 1)), s, refProbes(s), 0);
    end

    repeat (4) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmp_search.md
# cmp_search

Sequential successive-approximation searcher for the comparator datapath. The comparator answers "how does x relate to y"; this block asks the questions. It drives a trial value onto the comparator's y input while x holds an unknown secret. It reads back eq/lt/gt and, one bit per cycle from MSB to LSB, recovers the secret with a start/done handshake. The bench closes the loop with the existing cmp4b comparator (x = secret, y = guess).

## Interface
- W, 4, operand width in bits; the comparator must be W bits wide.
- clk  in  1  rising-edge clock.
- rst_b  in  1  asynchronous reset, active-low.
- start  in  1  request a new search; sampled only in IDLE.
- guess  out  W  trial value driven to comparator y.
- eq  in  1  comparator: secret == guess.
- lt  in  1  comparator: secret < guess.
- gt  in  1  comparator: secret > guess.
- busy  out  1  high while in PROBE.
- done  out  1  one-cycle pulse when the search ends.
- result  out  W  recovered secret; held from done until the next accepted start.
- err  out  1  set at done if an inconsistent comparator answer aborted the search; held with result.
- probes  out  clog2(W+1)  number of comparisons used; held with result.

## Operation
- States:
  - IDLE: guess = 0, busy = 0.
  - PROBE: guess = acc | (1 << bitidx), busy = 1.
  - DONE: done = 1 for exactly one cycle, then back to IDLE.
- IDLE with start = 1: acc <= 0, bitidx <= W-1, cnt <= 0, err cleared, then go to PROBE.
- PROBE, at each edge, sample eq/lt/gt against the current guess and increment cnt:
  - exactly eq: acc <= guess, go to DONE (early exit).
  - exactly gt: acc <= guess (keep the bit).
  - exactly lt: acc unchanged (drop the bit).
  - not exactly one asserted (none, or two or more): err <= 1, acc unchanged, go to DONE.
  - gt or lt with bitidx == 0: go to DONE. Otherwise bitidx <= bitidx - 1.
- On entry to DONE: result <= acc, probes <= cnt.
- start while in PROBE or DONE is ignored; it does not queue.
- Arithmetic is unsigned. guess never exceeds 2^W - 1. acc only gains bits, never loses them.

## Timing
- Reset values: state IDLE, guess 0, busy 0, done 0, result 0, err 0, probes 0, acc 0.
- Reset asserted mid-search forces all of the above immediately (asynchronous). No done pulse is emitted.
- eq/lt/gt are combinational from guess. guess is combinational from registers only (acc, bitidx, state) and is stable for the whole PROBE cycle.
- Start accepted at edge 0. Probe k (k = 1..W) occupies the cycle after edge k-1. done is high in the cycle after the final probe.
- Worst-case latency is start edge to done high in W+1 cycles. An eq exit at probe k gives done k+1 cycles after the start edge.
- A new start is accepted earliest in the cycle after done. There is no back-to-back overlap.

## Structure
- Shared package cmp_pkg holds:
  - the state enum (IDLE, PROBE, DONE);
  - the default width constant W = 4;
  - a helper constant for the probe-count width.
- Single module; no sub-module needed. The comparator stays external so the same searcher runs against cmp4b or a behavioural model.

## Test plan
- Secret 0: guesses 8,4,2,1 all answer lt → result 0, probes 4, err 0, done 5 cycles after start.
- Secret 11: 8 gt, 12 lt, 10 gt, 11 eq → result 11, probes 4.
- Secret 8: first guess 8 answers eq → result 8, probes 1, done 2 cycles after start.
- Secret 15: 8,12,14 gt, 15 eq → result 15, probes 4. Sweep all 16 secrets: result == secret, err 0.
- Behavioural comparator drives eq=1 and lt=1 on probe 2 → err 1, result 8 (from probe 1 gt, secret ≥ 8), probes 2.
- Pulse rst_b low during probe 3 → all outputs at reset values at once, no done. Start again afterwards completes normally. start pulsed while busy has no effect on the result.
